// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared opcode constants, NOP encoding, state type and
//                register-usage decode helpers for the hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // RV32I major opcodes, inst[6:2]
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [0:0] {
        HZ_RUN    = 1'b0,
        HZ_FREEZE = 1'b1
    } hz_state_e;

    // Every format except U-type and JAL carries a real rs1 field
    function automatic logic rs1_used(input logic [4:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    // Only R-type, stores and branches read rs2
    function automatic logic rs2_used(input logic [4:0] op);
        return (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_perf_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_perf_counter
//  Description : Free-running event counter with enable; wraps modulo
//                2^WIDTH. Used for stall/flush statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Next count: increment on each enabled cycle, natural wrap
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Stall/flush controller for the 5-stage RV32 pipeline.
//                Handles load-use stalls, branch/jump flushes and LSU
//                freezes with a hung-LSU watchdog. Optional performance
//                counters are built when HAZARD_PERF_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FREEZE_LIMIT = 255,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] id_inst_i,
    input  logic [DATA_WIDTH-1:0] ex_inst_i,
    input  logic [DATA_WIDTH-1:0] mem_inst_i,
    input  logic                  br_taken_i,
    input  logic                  mem_ready_i,
    output logic                  pc_en_o,
    output logic                  if_id_en_o,
    output logic                  id_ex_en_o,
    output logic                  ex_mem_en_o,
    output logic                  mem_wb_en_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  mem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
`endif
);

    localparam int             FC_W   = $clog2(FREEZE_LIMIT + 1);
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FREEZE_LIMIT);

    hz_state_e       state_d, state_q;
    logic [FC_W-1:0] fcnt_d, fcnt_q;
    logic            tmo_d, tmo_q;

    logic [4:0] w_id_op, w_ex_op, w_mem_op;
    logic [4:0] w_id_rs1, w_id_rs2, w_ex_rd;
    logic       w_mem_busy, w_load_use, w_hold;
    logic       w_unused_bits;

    assign w_id_op  = id_inst_i[6:2];
    assign w_ex_op  = ex_inst_i[6:2];
    assign w_mem_op = mem_inst_i[6:2];
    assign w_id_rs1 = id_inst_i[19:15];
    assign w_id_rs2 = id_inst_i[24:20];
    assign w_ex_rd  = ex_inst_i[11:7];

    // Fields of the instruction words that the hazard logic never inspects
    assign w_unused_bits = ^{id_inst_i, ex_inst_i, mem_inst_i};

    assign w_mem_busy = ((w_mem_op == OP_LOAD) || (w_mem_op == OP_STORE)) && !mem_ready_i;

    assign w_load_use = (w_ex_op == OP_LOAD) && (w_ex_rd != 5'd0) &&
                        ((rs1_used(w_id_op) && (w_ex_rd == w_id_rs1)) ||
                         (rs2_used(w_id_op) && (w_ex_rd == w_id_rs2)));

    // Whole pipeline held: first busy cycle in RUN, or FREEZE still waiting.
    // In the release cycle of FREEZE the busy term is deliberately ignored.
    assign w_hold = (state_q == HZ_RUN) ? w_mem_busy : !mem_ready_i;

    // Mealy output decision; reset forces every register to flush-and-hold
    always_comb begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        id_ex_en_o    = 1'b1;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        if (!rst_ni) begin
            {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b00000;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (w_hold) begin
            {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b00000;
        end else if (br_taken_i) begin
            // The load-use victim sits in ID and is killed by this flush
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (w_load_use) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    // Next state, freeze watchdog counter and sticky timeout
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            HZ_RUN: begin
                if (w_mem_busy) begin
                    state_d = HZ_FREEZE;
                    fcnt_d  = '0;
                end
            end
            HZ_FREEZE: begin
                if (!mem_ready_i) begin
                    if (fcnt_q != FC_MAX) begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                    if (fcnt_d == FC_MAX) begin
                        tmo_d = 1'b1;
                    end
                end else begin
                    state_d = HZ_RUN;
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HZ_RUN;
            fcnt_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign mem_timeout_o = tmo_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (!pc_en_o),
        .cnt_o  (stall_cnt_o)
    );

    hazard_perf_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (if_id_flush_o && rst_ni),
        .cnt_o  (flush_cnt_o)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_controller
//  Description : Directed self-checking bench for hazard_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

    localparam logic [31:0] I_NOP   = 32'h00000013;
    localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
    localparam logic [31:0] I_ADD5  = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] I_ADD0  = 32'h00200333; // add  x6,x0,x2
    localparam logic [31:0] I_LUI   = 32'h00028337; // lui  x6,0x28 (rs1 field = 5)
    localparam logic [31:0] I_ADDI7 = 32'h00538313; // addi x6,x7,5 (rs2 field = 5)
    localparam logic [31:0] I_ADDI5 = 32'h00028313; // addi x6,x5,0
    localparam logic [31:0] I_SW    = 32'h0020A023; // sw   x2,0(x1)

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    localparam logic [6:0] O_RUN   = 7'b1111100;
    localparam logic [6:0] O_STALL = 7'b0011101;
    localparam logic [6:0] O_FLUSH = 7'b1111111;
    localparam logic [6:0] O_HOLD  = 7'b0000000;
    localparam logic [6:0] O_RST   = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_inst, ex_inst, mem_inst;
    logic        br_taken, mem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif
    logic [6:0]  outs;

    int total = 0;
    int bad   = 0;

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

    always #5 clk = ~clk;

    hazard_controller #(
        .DATA_WIDTH   (32),
        .FREEZE_LIMIT (4),
        .CNT_WIDTH    (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .id_inst_i     (id_inst),
        .ex_inst_i     (ex_inst),
        .mem_inst_i    (mem_inst),
        .br_taken_i    (br_taken),
        .mem_ready_i   (mem_ready),
        .pc_en_o       (pc_en),
        .if_id_en_o    (if_id_en),
        .id_ex_en_o    (id_ex_en),
        .ex_mem_en_o   (ex_mem_en),
        .mem_wb_en_o   (mem_wb_en),
        .if_id_flush_o (if_id_flush),
        .id_ex_flush_o (id_ex_flush),
        .mem_timeout_o (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
`endif
    );

    // Advance past the next rising edge before driving new inputs
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_inst = I_NOP; ex_inst = I_NOP; mem_inst = I_NOP;
        br_taken = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (outs !== O_RST) begin bad++; $display("FAIL reset_outs: got %b expected %b", outs, O_RST); end
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b expected 0", mem_timeout); end
        rst_n = 1'b1;
        #1;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL reset_release: got %b expected %b", outs, O_RUN); end
    endtask

    task automatic test_load_use();
        cyc(); ex_inst = I_LW5; id_inst = I_ADD5; mem_inst = I_NOP;
        @(negedge clk);
        total++; if (outs !== O_STALL) begin bad++; $display("FAIL load_use_stall: got %b expected %b", outs, O_STALL); end
        cyc(); ex_inst = I_NOP; mem_inst = I_LW5; mem_ready = 1'b1;
        @(negedge clk);
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL load_use_release: got %b expected %b", outs, O_RUN); end
    endtask

    task automatic test_no_false_stall();
        cyc(); ex_inst = I_LW0; id_inst = I_ADD0; mem_inst = I_NOP;
        @(negedge clk);
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL rd_zero: got %b expected %b", outs, O_RUN); end
        cyc(); ex_inst = I_LW5; id_inst = I_LUI;
        @(negedge clk);
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL lui_no_rs1: got %b expected %b", outs, O_RUN); end
        cyc(); id_inst = I_ADDI7;
        @(negedge clk);
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL addi_no_rs2: got %b expected %b", outs, O_RUN); end
        cyc(); id_inst = I_ADDI5;
        @(negedge clk);
        total++; if (outs !== O_STALL) begin bad++; $display("FAIL addi_rs1_stall: got %b expected %b", outs, O_STALL); end
    endtask

    task automatic test_branch();
        cyc(); ex_inst = I_LW5; id_inst = I_ADD5; br_taken = 1'b1;
        @(negedge clk);
        total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL branch_over_load_use: got %b expected %b", outs, O_FLUSH); end
        cyc(); idle_inputs();
    endtask

    task automatic test_freeze_branch();
        cyc(); mem_inst = I_SW; mem_ready = 1'b0; br_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (outs !== O_HOLD) begin bad++; $display("FAIL freeze_hold%0d: got %b expected %b", k, outs, O_HOLD); end
            if (k < 2) cyc();
        end
        cyc(); mem_ready = 1'b1;
        @(negedge clk);
        total++; if (outs !== O_FLUSH) begin bad++; $display("FAIL freeze_release_flush: got %b expected %b", outs, O_FLUSH); end
        // Back in RUN: not-ready with no memory op must not hold anything
        cyc(); mem_inst = I_NOP; br_taken = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL freeze_back_to_run: got %b expected %b", outs, O_RUN); end
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL freeze_no_timeout: got %b expected 0", mem_timeout); end
    endtask

    task automatic test_timeout();
        cyc(); mem_inst = I_LW5; mem_ready = 1'b0;
        @(negedge clk);
        total++; if (outs !== O_HOLD || mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_first: got %b/%b expected %b/0", outs, mem_timeout, O_HOLD); end
        // After k edges, k-1 of them were taken in FREEZE; limit 4 is hit at k=5
        for (int k = 1; k <= 5; k++) begin
            cyc();
            @(negedge clk);
            total++;
            if (mem_timeout !== (k >= 5) || outs !== O_HOLD) begin
                bad++; $display("FAIL timeout_step%0d: got %b/%b expected %b/%b", k, outs, mem_timeout, O_HOLD, (k >= 5));
            end
        end
        cyc(); mem_ready = 1'b1;
        @(negedge clk);
        total++; if (outs !== O_RUN || mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_release: got %b/%b expected %b/1", outs, mem_timeout, O_RUN); end
        cyc(); mem_inst = I_NOP;
        @(negedge clk);
        total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b expected 1", mem_timeout); end
    endtask

    task automatic test_reset_mid_freeze();
        cyc(); mem_inst = I_SW; mem_ready = 1'b0;
        @(negedge clk);
        total++; if (outs !== O_HOLD) begin bad++; $display("FAIL midrst_pre: got %b expected %b", outs, O_HOLD); end
        cyc(); #2;
        rst_n = 1'b0;
        #1;
        total++; if (outs !== O_RST) begin bad++; $display("FAIL midrst_outs: got %b expected %b", outs, O_RST); end
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL midrst_timeout: got %b expected 0", mem_timeout); end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        total++; if (outs !== O_RUN) begin bad++; $display("FAIL midrst_release: got %b expected %b", outs, O_RUN); end
`ifdef HAZARD_PERF_CNT_EN
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin bad++; $display("FAIL cnt_after_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
        cyc(); ex_inst = I_LW5; id_inst = I_ADD5;
        cyc(); idle_inputs(); br_taken = 1'b1;
        @(negedge clk);
        total++; if (stall_cnt !== 32'd1 || flush_cnt !== 32'd0) begin bad++; $display("FAIL cnt_stall: got %0d/%0d expected 1/0", stall_cnt, flush_cnt); end
        cyc(); br_taken = 1'b0;
        @(negedge clk);
        total++; if (stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin bad++; $display("FAIL cnt_flush: got %0d/%0d expected 1/1", stall_cnt, flush_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_branch();
        test_freeze_branch();
        test_timeout();
        test_reset_mid_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
